// File: rtl/afe_model_pkg.sv
// ---------------------------------------------------------------------------
// afe_model_pkg : shared state type, constants and output saturation helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package afe_model_pkg;

  typedef enum logic [1:0] {
    DARK   = 2'd0,
    SETTLE = 2'd1,
    TRACK  = 2'd2
  } afe_state_e;

  localparam logic signed [7:0]  TRI_MAX = 8'sd64;
  localparam logic signed [15:0] ADC_MID = 16'sd128;

  function automatic logic [7:0] sat8(input logic signed [15:0] v);
    if (v < 16'sd0)
      return 8'd0;
    else if (v > 16'sd255)
      return 8'd255;
    else
      return v[7:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/afe_ppg_tri.sv
// ---------------------------------------------------------------------------
// afe_ppg_tri : free-running heartbeat triangle, -64..+64, one step per STEP_DIV
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module afe_ppg_tri
  import afe_model_pkg::*;
#(
  parameter int STEP_DIV = 4
) (
  input  logic              CLK,
  input  logic              rst,
  output logic signed [7:0] tri_o
);

  localparam int            CW        = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0]     step_cnt_q, step_cnt_d;
  logic signed [7:0] tri_q, tri_d;
  logic              down_q, down_d;
  logic              w_step;

  assign w_step = (step_cnt_q == STEP_LAST);

  // Reversal happens on the step after an endpoint, so each endpoint lasts one step.
  always_comb begin
    step_cnt_d = w_step ? '0 : step_cnt_q + 1'b1;
    tri_d      = tri_q;
    down_d     = down_q;
    if (w_step) begin
      if (!down_q) begin
        if (tri_q == TRI_MAX) begin
          tri_d  = tri_q - 8'sd1;
          down_d = 1'b1;
        end else begin
          tri_d  = tri_q + 8'sd1;
        end
      end else begin
        if (tri_q == -TRI_MAX) begin
          tri_d  = tri_q + 8'sd1;
          down_d = 1'b0;
        end else begin
          tri_d  = tri_q - 8'sd1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      step_cnt_q <= '0;
      tri_q      <= 8'sd0;
      down_q     <= 1'b0;
    end else begin
      step_cnt_q <= step_cnt_d;
      tri_q      <= tri_d;
      down_q     <= down_d;
    end
  end

  assign tri_o = tri_q;

endmodule

`default_nettype wire

// File: rtl/afe_sensor_model.sv
// ---------------------------------------------------------------------------
// afe_sensor_model : LED/photodiode/DC-comp/PGA/8-bit ADC model with PPG signal
// Optional macro AFE_NOISE_EN adds LFSR noise to the photodiode value. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module afe_sensor_model
  import afe_model_pkg::*;
#(
  parameter int K_LED         = 12,
  parameter int COMP_STEP     = 2,
  parameter int AC_RED        = 24,
  parameter int AC_IR         = 32,
  parameter int AMBIENT       = 8,
  parameter int STEP_DIV      = 4,
  parameter int SETTLE_CYCLES = 6
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic [3:0] LED_DRIVE,
  input  logic [6:0] DC_Comp,
  input  logic [3:0] PGA_Gain,
  input  logic       LED_RED,
  input  logic       LED_IR,
  input  logic       CLK_Filter,
  output logic [7:0] ADC,
  output logic       ADC_valid
);

  localparam int                SCW         = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SCW-1:0]    SETTLE_LOAD = SCW'(SETTLE_CYCLES - 1);
  localparam logic signed [15:0] C_K_LED     = 16'(K_LED);
  localparam logic signed [15:0] C_COMP_STEP = 16'(COMP_STEP);
  localparam logic signed [15:0] C_AC_RED    = 16'(AC_RED);
  localparam logic signed [15:0] C_AC_IR     = 16'(AC_IR);
  localparam logic signed [15:0] C_AMBIENT   = 16'(AMBIENT);

  logic signed [7:0]  w_tri;
  logic signed [15:0] w_tri_ext, w_dc, w_red_ch, w_ir_ch, w_s_raw, w_s_noisy;
  logic [9:0]         w_s;
  logic signed [15:0] w_c, w_gain, w_g;
  logic [7:0]         w_code;

  afe_state_e         state_q, state_d;
  logic [SCW-1:0]     settle_cnt_q, settle_cnt_d;
  logic [1:0]         sel_q, w_sel;
  logic               w_sel_chg, w_conv_en;

  logic               cf_q, cf_prev_q, w_edge;
  logic               v1_q;
  logic [9:0]         s1_q;
  logic [6:0]         comp1_q;
  logic [3:0]         gain1_q;
  logic [7:0]         adc_q;
  logic               adc_valid_q;

  afe_ppg_tri #(
    .STEP_DIV (STEP_DIV)
  ) u_tri (
    .CLK   (CLK),
    .rst   (rst),
    .tri_o (w_tri)
  );

  // Photodiode front end
  assign w_tri_ext = {{8{w_tri[7]}}, w_tri};
  assign w_dc      = $signed({12'd0, LED_DRIVE}) * C_K_LED;
  assign w_red_ch  = w_dc + ((w_tri_ext * C_AC_RED) >>> 6);
  assign w_ir_ch   = w_dc + ((w_tri_ext * C_AC_IR) >>> 6);

  always_comb begin
    case (w_sel)
      2'b10:   w_s_raw = w_red_ch;
      2'b01:   w_s_raw = w_ir_ch;
      2'b11:   w_s_raw = w_red_ch + w_ir_ch;
      default: w_s_raw = C_AMBIENT;
    endcase
  end

`ifdef AFE_NOISE_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge CLK) begin
    if (rst)
      lfsr_q <= 16'hACE1;
    else
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign w_s_noisy = w_s_raw + $signed({{13{lfsr_q[2]}}, lfsr_q[2:0]});
`else
  assign w_s_noisy = w_s_raw;
`endif

  // Upper clamp is unreachable with legal parameters; it keeps the 10-bit cut explicit.
  assign w_s = (w_s_noisy < 16'sd0)    ? 10'd0 :
               (w_s_noisy > 16'sd1023) ? 10'd1023 : w_s_noisy[9:0];

  // Stage-2 arithmetic works only on values captured with the conversion
  assign w_c    = $signed({6'd0, s1_q}) - ($signed({9'd0, comp1_q}) * C_COMP_STEP);
  assign w_gain = $signed({12'd0, gain1_q}) + 16'sd1;
  assign w_g    = w_c * w_gain;
  assign w_code = sat8(w_g + ADC_MID);

  // Selection-tracking FSM
  assign w_sel     = {LED_RED, LED_IR};
  assign w_sel_chg = (w_sel != sel_q);

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q      <= DARK;
      settle_cnt_q <= '0;
      sel_q        <= 2'b00;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      sel_q        <= w_sel;
    end
  end

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    if (w_sel_chg) begin
      state_d      = SETTLE;
      settle_cnt_d = SETTLE_LOAD;
    end else begin
      case (state_q)
        DARK:    state_d = DARK;
        TRACK:   state_d = TRACK;
        SETTLE: begin
          if (settle_cnt_q == '0)
            state_d = (w_sel == 2'b00) ? DARK : TRACK;
          else
            settle_cnt_d = settle_cnt_q - 1'b1;
        end
        default: state_d = DARK;
      endcase
    end
  end

  // A selection change blocks in the same cycle, so an in-flight conversion dies too.
  always_comb begin
    w_conv_en = (state_q != SETTLE) && !w_sel_chg;
  end

  // Conversion pipeline
  assign w_edge = cf_q && !cf_prev_q;

  always_ff @(posedge CLK) begin
    if (rst) begin
      cf_q        <= 1'b0;
      cf_prev_q   <= 1'b0;
      v1_q        <= 1'b0;
      s1_q        <= '0;
      comp1_q     <= '0;
      gain1_q     <= '0;
      adc_q       <= 8'd0;
      adc_valid_q <= 1'b0;
    end else begin
      cf_q        <= CLK_Filter;
      cf_prev_q   <= cf_q;
      v1_q        <= w_edge && w_conv_en;
      if (w_edge && w_conv_en) begin
        s1_q    <= w_s;
        comp1_q <= DC_Comp;
        gain1_q <= PGA_Gain;
      end
      adc_valid_q <= v1_q && w_conv_en;
      if (v1_q && w_conv_en)
        adc_q <= w_code;
    end
  end

  assign ADC       = adc_q;
  assign ADC_valid = adc_valid_q;

endmodule

`default_nettype wire

// File: doc/afe_sensor_model.md
Name: afe_sensor_model

Overview:
- Synthesizable model of the pulse-oximeter analog front end (LEDs, photodiode, DC compensation DAC, PGA, 8-bit ADC).
- It is the responder on the controller's drive/ADC interface. It consumes LED_DRIVE, DC_Comp, PGA_Gain, LED_RED/LED_IR and CLK_Filter, and returns an ADC code carrying a synthetic PPG waveform.
- Used in closed-loop bench and FPGA bring-up, in place of the analog board.

Parameters:
- K_LED, 12: photodiode counts per LED_DRIVE step (DC baseline = LED_DRIVE*K_LED).
- COMP_STEP, 2: counts removed per DC_Comp LSB.
- AC_RED, 24: peak AC amplitude in counts, RED channel.
- AC_IR, 32: peak AC amplitude in counts, IR channel.
- AMBIENT, 8: photodiode counts with no LED lit.
- STEP_DIV, 4: CLK cycles per triangle step; heartbeat period = 256*STEP_DIV cycles.
- SETTLE_CYCLES, 6: CLK cycles ADC is held after an LED selection change.

Ports:
- CLK, input, 1: system clock.
- rst, input, 1: synchronous active-high reset.
- LED_DRIVE, input, 4: LED current code.
- DC_Comp, input, 7: DC compensation code.
- PGA_Gain, input, 4: gain code; gain = PGA_Gain+1.
- LED_RED, input, 1: RED LED on.
- LED_IR, input, 1: IR LED on.
- CLK_Filter, input, 1: filter/ADC clock; a conversion starts on its rising edge.
- ADC, output, 8: conversion result.
- ADC_valid, output, 1: one-cycle pulse when ADC takes a new value.

Behaviour:
- Interface: one clock CLK; reset rst is synchronous and active-high; all state updates on posedge CLK.
- Reset values: ADC=8'd0, ADC_valid=0, state=DARK, triangle tri=0 counting up, step counter=0, settle counter=0, CLK_Filter history=0, LED history=2'b00.
- Heartbeat generator:
  - Signed tri in [-64,+64] moves ±1 every STEP_DIV cycles.
  - Direction reverses on reaching +64 or -64; the endpoint value is held for exactly one step.
  - Runs continuously, independent of the FSM.
- Photodiode value s (unsigned, 10 bits):
  - RED only: LED_DRIVE*K_LED + ((tri*AC_RED)>>>6).
  - IR only: same, using AC_IR.
  - Both on: sum of both channel values.
  - Neither on: AMBIENT.
  - Clamp s at 0 from below.
- Compensation: c = s - DC_Comp*COMP_STEP, signed 12-bit.
- Gain: g = c*(PGA_Gain+1), signed 16-bit. No overflow is possible: |c| < 2^11 and gain ≤ 16.
- Code: ADC_next = saturate(128+g) to [0,255]; negative results give 0, results >255 give 255.
- Pipeline:
  - Rising-edge detect on registered CLK_Filter (prev=0, cur=1).
  - Stage 1 registers s; stage 2 registers the saturated code.
  - ADC and ADC_valid update 2 CLK after the detected edge.
  - Input changes after the edge do not affect that conversion.
- FSM, evaluated every cycle on {LED_RED,LED_IR} versus its registered history:
  - DARK: selection is 00. Conversions proceed (ambient path).
  - SETTLE: entered on any selection change, including from/to 00 and from TRACK. Counter loads SETTLE_CYCLES-1. ADC holds, ADC_valid is forced 0, and edges are dropped. When the counter reaches 0, go to TRACK, or to DARK if selection is 00.
  - TRACK: selection is non-zero and stable. Conversions proceed.
  - A change during SETTLE reloads the counter.
  - A conversion in flight when SETTLE is entered is discarded.
- CLK_Filter edge coincident with reset: ignored; reset wins everywhere.
- Reset mid-conversion: pipeline flushed; no valid pulse is emitted.

Optional Feature:
- AFE_NOISE_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) advances each CLK.
  - Its low 3 bits, as signed (-4..+3), are added to s before the clamp.
- AFE_NOISE_EN undefined: no LFSR, and the output is fully deterministic.

Decomposition:
- Package afe_model_pkg holds:
  - the state enum (DARK, SETTLE, TRACK);
  - the TRI_MAX=64 and ADC_MID=128 constants;
  - a saturate-to-8-bit function.
- One sub-module is natural: afe_ppg_tri, the heartbeat triangle generator. It has CLK and rst inputs and outputs signed 8-bit tri.

Test Plan:
- Reset: hold rst 3 cycles with CLK_Filter toggling -> ADC=0, ADC_valid never pulses, state DARK.
- DC null:
  - Stimulus: RED only, LED_DRIVE=10, DC_Comp=60, PGA_Gain=0.
  - After SETTLE: ADC = 128+((tri*24)>>>6), spanning 104..152 over one 1024-cycle heartbeat.
- Saturation: as the DC-null case but DC_Comp=127 and PGA_Gain=15 -> ADC=0 on every conversion. With LED_DRIVE=15, DC_Comp=0 -> ADC=255.
- Gain linearity: IR only, LED_DRIVE=10, DC_Comp=60, tri frozen by inspection at +32, PGA_Gain 0 vs 3 -> ADC 144 vs 192.
- Settle: switch RED to IR -> no ADC_valid for 6 cycles, ADC holds the last RED value. A second switch at cycle 3 restarts the 6-cycle hold.
- Timing: CLK_Filter edge at cycle n -> ADC_valid high at exactly n+2, one cycle wide; a DC_Comp change at n+1 is not reflected until the next conversion.
